// File: rtl/display_capture.sv
// Receiver for the scanned four-digit display bus: tracks A -> B -> RH -> RL anode
// order, rebuilds PortA/PortB/Result and publishes them atomically per good frame.
module display_capture #(
   parameter int LOCK_FRAMES = 2,
   parameter int ERR_W       = 8
) (
   input  logic             ClockA,
   input  logic             Reset,
   input  logic [3:0]       BCD,
   input  logic [3:0]       An,
   output logic [2:0]       PortA,
   output logic [2:0]       PortB,
   output logic [5:0]       Result,
   output logic             FrameValid,
   output logic             Locked,
   output logic             Error,
   output logic [ERR_W-1:0] ErrCount
);

   typedef enum logic [2:0] {HUNT, EXP_B, EXP_RH, EXP_RL, EXP_A} state_t;

   localparam logic [3:0] AN_A    = 4'b0111;
   localparam logic [3:0] AN_B    = 4'b1011;
   localparam logic [3:0] AN_RH   = 4'b1101;
   localparam logic [3:0] AN_RL   = 4'b1110;
   localparam logic [3:0] AN_IDLE = 4'b0000;
   localparam logic [3:0] LOCK_MAX = 4'(LOCK_FRAMES);

   state_t           state_reg, state_next;
   logic [2:0]       shadow_a_reg, shadow_a_next;
   logic [2:0]       shadow_b_reg, shadow_b_next;
   logic [1:0]       shadow_rh_reg, shadow_rh_next;
   logic [2:0]       port_a_reg, port_a_next;
   logic [2:0]       port_b_reg, port_b_next;
   logic [5:0]       result_reg, result_next;
   logic             frame_valid_reg, frame_valid_next;
   logic             error_reg, error_next;
   logic [3:0]       good_cnt_reg, good_cnt_next;
   logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

   logic is_a, is_b, is_rh, is_rl, is_idle, legal_a, accept;

   assign is_a    = (An == AN_A);
   assign is_b    = (An == AN_B);
   assign is_rh   = (An == AN_RH);
   assign is_rl   = (An == AN_RL);
   assign is_idle = (An == AN_IDLE);
   assign legal_a = is_a && !BCD[3];

   // Expected anode for the current slot, with its digit-width rule applied.
   always_comb begin
      accept = 1'b0;
      case (state_reg)
         EXP_B:   accept = is_b && !BCD[3];
         EXP_RH:  accept = is_rh && (BCD[3:2] == 2'b00);
         EXP_RL:  accept = is_rl;
         EXP_A:   accept = legal_a;
         default: accept = 1'b0;
      endcase
   end

   always_comb begin
      state_next       = state_reg;
      shadow_a_next    = shadow_a_reg;
      shadow_b_next    = shadow_b_reg;
      shadow_rh_next   = shadow_rh_reg;
      port_a_next      = port_a_reg;
      port_b_next      = port_b_reg;
      result_next      = result_reg;
      frame_valid_next = 1'b0;
      error_next       = 1'b0;
      good_cnt_next    = good_cnt_reg;
      err_cnt_next     = err_cnt_reg;

      if (state_reg == HUNT) begin
         if (is_a) begin
            shadow_a_next = BCD[2:0];
            state_next    = EXP_B;
         end
      end else if (is_idle) begin
         state_next    = HUNT;
         good_cnt_next = 4'd0;
      end else if (accept) begin
         case (state_reg)
            EXP_B: begin
               shadow_b_next = BCD[2:0];
               state_next    = EXP_RH;
            end
            EXP_RH: begin
               shadow_rh_next = BCD[1:0];
               state_next     = EXP_RL;
            end
            EXP_RL: begin
               port_a_next      = shadow_a_reg;
               port_b_next      = shadow_b_reg;
               result_next      = {shadow_rh_reg, BCD};
               frame_valid_next = 1'b1;
               if (good_cnt_reg != LOCK_MAX)
                  good_cnt_next = good_cnt_reg + 4'd1;
               state_next       = EXP_A;
            end
            default: begin
               shadow_a_next = BCD[2:0];
               state_next    = EXP_B;
            end
         endcase
      end else begin
         error_next    = 1'b1;
         good_cnt_next = 4'd0;
         if (err_cnt_reg != {ERR_W{1'b1}})
            err_cnt_next = err_cnt_reg + 1'b1;
         // A well-formed A digit restarts the frame immediately instead of hunting.
         if (legal_a) begin
            shadow_a_next = BCD[2:0];
            state_next    = EXP_B;
         end else begin
            state_next = HUNT;
         end
      end
   end

   always_ff @(posedge ClockA) begin
      if (Reset) begin
         state_reg       <= HUNT;
         shadow_a_reg    <= '0;
         shadow_b_reg    <= '0;
         shadow_rh_reg   <= '0;
         port_a_reg      <= '0;
         port_b_reg      <= '0;
         result_reg      <= '0;
         frame_valid_reg <= 1'b0;
         error_reg       <= 1'b0;
         good_cnt_reg    <= '0;
         err_cnt_reg     <= '0;
      end else begin
         state_reg       <= state_next;
         shadow_a_reg    <= shadow_a_next;
         shadow_b_reg    <= shadow_b_next;
         shadow_rh_reg   <= shadow_rh_next;
         port_a_reg      <= port_a_next;
         port_b_reg      <= port_b_next;
         result_reg      <= result_next;
         frame_valid_reg <= frame_valid_next;
         error_reg       <= error_next;
         good_cnt_reg    <= good_cnt_next;
         err_cnt_reg     <= err_cnt_next;
      end
   end

   assign PortA      = port_a_reg;
   assign PortB      = port_b_reg;
   assign Result     = result_reg;
   assign FrameValid = frame_valid_reg;
   assign Error      = error_reg;
   assign ErrCount   = err_cnt_reg;
   assign Locked     = (good_cnt_reg == LOCK_MAX);

endmodule

// File: tb/tb_display_capture.sv
// Scoreboard bench for display_capture: stimulus queues expected strobes with their
// due cycle, an independent monitor pops and compares on every FrameValid/Error.
module tb_display_capture;

   localparam logic [3:0] AN_A    = 4'b0111;
   localparam logic [3:0] AN_B    = 4'b1011;
   localparam logic [3:0] AN_RH   = 4'b1101;
   localparam logic [3:0] AN_RL   = 4'b1110;
   localparam logic [3:0] AN_IDLE = 4'b0000;

   logic       ClockA = 1'b0;
   logic       Reset  = 1'b1;
   logic [3:0] BCD    = 4'd0;
   logic [3:0] An     = 4'd0;
   logic [2:0] PortA, PortB;
   logic [5:0] Result;
   logic       FrameValid, Locked, Error;
   logic [7:0] ErrCount;

   display_capture #(.LOCK_FRAMES(2), .ERR_W(8)) dut (
      .ClockA(ClockA), .Reset(Reset), .BCD(BCD), .An(An),
      .PortA(PortA), .PortB(PortB), .Result(Result),
      .FrameValid(FrameValid), .Locked(Locked), .Error(Error), .ErrCount(ErrCount)
   );

   always #5 ClockA = ~ClockA;

   int cyc = 0;
   always @(posedge ClockA) cyc <= cyc + 1;

   typedef struct {
      bit is_err;
      int due;
      int pa;
      int pb;
      int res;
      int lk;
      int ec;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic slot(input logic [3:0] an, input logic [3:0] bcd);
      @(negedge ClockA);
      An  = an;
      BCD = bcd;
   endtask

   task automatic frame(input int a, input int b, input int rh, input int rl);
      slot(AN_A, 4'(a));
      slot(AN_B, 4'(b));
      slot(AN_RH, 4'(rh));
      slot(AN_RL, 4'(rl));
   endtask

   // Call right after driving the completing/offending slot.
   task automatic push(input bit is_err, input int pa, input int pb, input int res,
                       input int lk, input int ec);
      exp_t e;
      e.is_err = is_err; e.due = cyc + 1;
      e.pa = pa; e.pb = pb; e.res = res; e.lk = lk; e.ec = ec;
      q.push_back(e);
   endtask

   // Monitor
   always @(negedge ClockA) begin
      exp_t e;
      while (q.size() > 0 && q[0].due < cyc) begin
         e = q.pop_front();
         checks++; errors++;
         $display("FAIL missing_strobe actual=none required=%s at cycle %0d",
                  e.is_err ? "Error" : "FrameValid", e.due);
      end
      if (FrameValid || Error) begin
         chk("strobe_exclusive", int'(FrameValid && Error), 0);
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe actual=FV%0d/ERR%0d required=none cycle %0d",
                     FrameValid, Error, cyc);
         end else begin
            e = q.pop_front();
            chk("strobe_kind_error", int'(Error), int'(e.is_err));
            chk("latency_cycle", cyc, e.due);
            chk("PortA", int'(PortA), e.pa);
            chk("PortB", int'(PortB), e.pb);
            chk("Result", int'(Result), e.res);
            chk("Locked", int'(Locked), e.lk);
            chk("ErrCount", int'(ErrCount), e.ec);
            $display("cycle %0d %s a=%0d b=%0d r=%0d locked=%0d errcnt=%0d",
                     cyc, Error ? "error" : "frame", PortA, PortB, Result, Locked, ErrCount);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge ClockA);
      @(negedge ClockA);
      chk("reset_PortA", int'(PortA), 0);
      chk("reset_PortB", int'(PortB), 0);
      chk("reset_Result", int'(Result), 0);
      chk("reset_FrameValid", int'(FrameValid), 0);
      chk("reset_Locked", int'(Locked), 0);
      chk("reset_Error", int'(Error), 0);
      chk("reset_ErrCount", int'(ErrCount), 0);
      Reset = 1'b0;

      // Basic frame: 5/3/{2,C} -> Result = 0b10_1100 = 44
      frame(5, 3, 2, 4'hC);  push(0, 5, 3, 44, 0, 0);
      slot(AN_IDLE, 0);

      // Three back-to-back frames; lock on the second
      frame(5, 3, 2, 4'hC);  push(0, 5, 3, 44, 0, 0);
      frame(5, 3, 2, 4'hC);  push(0, 5, 3, 44, 1, 0);
      frame(5, 3, 2, 4'hC);  push(0, 5, 3, 44, 1, 0);

      // Mid-frame entry after idle: RH/RL ignored in HUNT
      slot(AN_IDLE, 0);
      slot(AN_RH, 2);
      slot(AN_RL, 4'hC);
      frame(5, 3, 2, 4'hC);  push(0, 5, 3, 44, 0, 0);
      frame(5, 3, 2, 4'hC);  push(0, 5, 3, 44, 1, 0);

      // Skipped B slot while locked
      slot(AN_A, 5);
      slot(AN_RH, 2);        push(1, 5, 3, 44, 0, 1);
      frame(1, 2, 0, 7);     push(0, 1, 2, 7, 0, 1);

      // A digit width violation (1010)
      slot(AN_A, 4'hA);      push(1, 1, 2, 7, 0, 2);
      frame(1, 2, 0, 7);     push(0, 1, 2, 7, 0, 2);
      frame(1, 2, 0, 7);     push(0, 1, 2, 7, 1, 2);

      // Idle mid-frame drops lock without Error
      slot(AN_A, 1);
      slot(AN_B, 2);
      chk("locked_before_idle", int'(Locked), 1);
      slot(AN_IDLE, 0);
      slot(AN_IDLE, 0);
      chk("locked_after_idle", int'(Locked), 0);
      chk("error_after_idle", int'(Error), 0);

      // RH width violation (digit 4)
      slot(AN_A, 1);
      slot(AN_B, 2);
      slot(AN_RH, 4);        push(1, 1, 2, 7, 0, 3);

      // Reset during EXP_RL, with RL on the bus in the same edge and the next
      slot(AN_A, 5);
      slot(AN_B, 3);
      slot(AN_RH, 2);
      @(negedge ClockA);
      Reset = 1'b1; An = AN_RL; BCD = 4'hC;
      @(negedge ClockA);
      Reset = 1'b0;
      chk("midreset_PortA", int'(PortA), 0);
      chk("midreset_PortB", int'(PortB), 0);
      chk("midreset_Result", int'(Result), 0);
      chk("midreset_ErrCount", int'(ErrCount), 0);
      chk("midreset_Locked", int'(Locked), 0);
      frame(5, 3, 2, 4'hC);  push(0, 5, 3, 44, 0, 0);

      // Hold A: first accepted, each following one is an error; saturate at 255
      for (int n = 1; n <= 301; n++) begin
         slot(AN_A, 1);
         if (n > 1) push(1, 5, 3, 44, 0, (n - 1 > 255) ? 255 : n - 1);
      end

      repeat (6) slot(AN_IDLE, 0);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
